// File: rtl/sram_rq_arbiter.sv
// N-channel arbiter in front of one SRAM request/response port. Grants are held
// across back-pressure, and an in-order tag FIFO routes each read return home.
module sram_rq_arbiter #(
    parameter int numChannels    = 4,
    parameter int numRows        = 128,
    parameter int numCols        = 32,
    parameter int maxOutstanding = 4,
    localparam int addrBits      = $clog2(numRows),
    localparam int tagBits       = (numChannels > 1) ? $clog2(numChannels) : 1,
    localparam int cntBits       = $clog2(maxOutstanding + 1)
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            mode_fixed_prio_i,
    input  logic [numChannels-1:0]          ch_rq_valid_i,
    input  logic [numChannels-1:0]          ch_rq_wr_i,
    input  logic [numChannels*addrBits-1:0] ch_addr_i,
    input  logic [numChannels*numCols-1:0]  ch_wr_data_i,
    output logic [numChannels-1:0]          ch_rq_ready_o,
    output logic [numChannels-1:0]          ch_rd_valid_o,
    output logic [numCols-1:0]              ch_rd_data_o,
    output logic                            sram_rq_valid_o,
    output logic                            sram_rq_wr_o,
    output logic [addrBits-1:0]             sram_addr_o,
    output logic [numCols-1:0]              sram_wr_data_o,
    input  logic                            sram_rq_ready_i,
    input  logic                            sram_rd_valid_i,
    input  logic [numCols-1:0]              sram_rd_data_i,
    output logic [cntBits-1:0]              outstanding_o,
    output logic                            err_unexpected_rd_o
);
    localparam int ptrBits = (maxOutstanding > 1) ? $clog2(maxOutstanding) : 1;

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; once valid is raised the requester holds valid and payload until then.

    logic [tagBits-1:0]     rr_ptr_q, rr_ptr_d;
    logic [tagBits-1:0]     locked_ch_q, locked_ch_d;
    logic                   lock_q, lock_d;
    logic [tagBits-1:0]     tag_mem_q [maxOutstanding];
    logic [ptrBits-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cntBits-1:0]     count_q, count_d;
    logic [numChannels-1:0] rd_valid_q, rd_valid_d;
    logic [numCols-1:0]     rd_data_q, rd_data_d;
    logic                   err_q, err_d;

    logic                   grant_vld;
    logic [tagBits-1:0]     grant_ch;
    logic                   fifo_full, fifo_empty, fire, push, pop;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (lock_q) begin
            grant_vld = 1'b1;
            grant_ch  = locked_ch_q;
        end else if (mode_fixed_prio_i) begin
            for (int i = numChannels - 1; i >= 0; i--) begin
                if (ch_rq_valid_i[i]) begin
                    grant_vld = 1'b1;
                    grant_ch  = tagBits'(i);
                end
            end
        end else begin
            // Descending scan so the closest channel at or after rr_ptr wins last.
            for (int i = numChannels - 1; i >= 0; i--) begin
                idx = (int'(rr_ptr_q) + i) % numChannels;
                if (ch_rq_valid_i[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = tagBits'(idx);
                end
            end
        end
    end

    assign fifo_full  = (count_q == cntBits'(maxOutstanding));
    assign fifo_empty = (count_q == '0);

    assign sram_rq_wr_o    = ch_rq_wr_i[grant_ch];
    assign sram_addr_o     = ch_addr_i[grant_ch*addrBits +: addrBits];
    assign sram_wr_data_o  = ch_wr_data_i[grant_ch*numCols +: numCols];
    assign sram_rq_valid_o = grant_vld & (sram_rq_wr_o | ~fifo_full);

    assign fire = sram_rq_valid_o & sram_rq_ready_i;
    assign push = fire & ~sram_rq_wr_o;
    assign pop  = sram_rd_valid_i & ~fifo_empty;

    always_comb begin
        ch_rq_ready_o = '0;
        if (fire) ch_rq_ready_o[grant_ch] = 1'b1;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_ch_d = locked_ch_q;
        if (fire) begin
            rr_ptr_d = (grant_ch == tagBits'(numChannels - 1)) ? '0 : grant_ch + 1'b1;
            lock_d   = 1'b0;
        end else if (grant_vld) begin
            lock_d      = 1'b1;
            locked_ch_d = grant_ch;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == ptrBits'(maxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == ptrBits'(maxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        err_d      = err_q | (sram_rd_valid_i & fifo_empty);
        if (pop) begin
            rd_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            rd_data_d                       = sram_rd_data_i;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_ch_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < maxOutstanding; i++) tag_mem_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_ch_q <= locked_ch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            if (push) tag_mem_q[wr_ptr_q] <= grant_ch;
        end
    end

    assign ch_rd_valid_o       = rd_valid_q;
    assign ch_rd_data_o        = rd_data_q;
    assign outstanding_o       = count_q;
    assign err_unexpected_rd_o = err_q;

endmodule

// File: doc/sram_rq_arbiter.md
# sram_rq_arbiter

Parametrised N-channel request arbiter in front of one SRAM macro's request/response port (rq_valid/rq_ready request handshake, rd_valid read return). It grants one requester per cycle using round-robin or fixed priority, and holds a grant stable across SRAM back-pressure. It tracks outstanding reads in an in-order tag FIFO and routes each returned read word back to the channel that issued it. It sits between the activation-buffer and feature-loader and weight-load engines on one side and a single sram_itf slave on the other.

## Interface
Parameters:
- numChannels, 4, number of requesting channels (≥1)
- numRows, 128, SRAM depth; addrBits = $clog2(numRows)
- numCols, 32, SRAM word width
- maxOutstanding, 4, tag FIFO depth (≥1); tagBits = max(1, $clog2(numChannels))

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- mode_fixed_prio_i  in  1  1: fixed priority, lowest index wins; 0: round-robin
- ch_rq_valid_i  in  numChannels  per-channel request valid
- ch_rq_wr_i  in  numChannels  per-channel 1=write, 0=read
- ch_addr_i  in  numChannels*addrBits  packed addresses, channel c at [c*addrBits +: addrBits]
- ch_wr_data_i  in  numChannels*numCols  packed write data
- ch_rq_ready_o  out  numChannels  one-hot or zero; request accepted when valid&ready
- ch_rd_valid_o  out  numChannels  one-hot or zero; registered read-return strobe
- ch_rd_data_o  out  numCols  registered read data, shared by all channels
- sram_rq_valid_o  out  1  request to SRAM
- sram_rq_wr_o  out  1  forwarded write flag
- sram_addr_o  out  addrBits  forwarded address
- sram_wr_data_o  out  numCols  forwarded write data
- sram_rq_ready_i  in  1  SRAM accepts request
- sram_rd_valid_i  in  1  SRAM read data valid
- sram_rd_data_i  in  numCols  SRAM read data
- outstanding_o  out  $clog2(maxOutstanding+1)  reads in flight
- err_unexpected_rd_o  out  1  sticky: rd_valid seen with FIFO empty

## Operation
- Grant selection (combinational), when not locked: round-robin searches from rr_ptr upward with wrap and picks the first channel with valid set; fixed priority picks the lowest index with valid set. No valid channel means no grant.
- When locked, the grant is locked_ch regardless of mode or other valids.
- Issue: sram_rq_valid_o = grant exists AND (write OR FIFO not full). The sram_rq_wr_o, addr and wr_data outputs mux the granted channel. A granted channel's payload is forwarded even when it is blocked.
- ch_rq_ready_o[g] = sram_rq_valid_o & sram_rq_ready_i. All other bits are 0.
- Handshake (fire) = sram_rq_valid_o & sram_rq_ready_i. On fire: rr_ptr ← (g+1) mod numChannels and the lock clears. A read fire pushes g into the tag FIFO.
- Lock: if a grant exists and there is no fire (SRAM not ready, or read blocked on a full FIFO), the lock is set and locked_ch ← g. Requesters must hold valid and payload stable until ready.
- Return: on sram_rd_valid_i with the FIFO non-empty, pop tag t. Next cycle ch_rd_valid_o = one-hot(t) and ch_rd_data_o = sram_rd_data_i.
- Return with the FIFO empty: the word is dropped, ch_rd_valid_o stays 0, and err_unexpected_rd_o is set (sticky until reset).
- FIFO full: a read push is blocked even if a pop occurs in the same cycle. A pop and a non-full push in the same cycle leave the count unchanged.
- Writes never touch the FIFO and are never blocked by it.
- Changing the mode mid-lock has no effect until the lock clears.

## Timing
- Request path is zero-latency combinational from ch_* and sram_rq_ready_i.
- Read return adds one cycle of latency after sram_rd_valid_i.
- Reset (asynchronous, any time, including mid-transfer) sets:
  - rr_ptr=0, lock=0, FIFO empty, outstanding_o=0
  - ch_rd_valid_o=0, ch_rd_data_o=0, err_unexpected_rd_o=0
  - Outstanding reads are forgotten; their later returns flag the error.
- Combinational outputs during reset follow the inputs with the state at reset values (rr_ptr=0, unlocked).
- Throughput is one request per cycle when sram_rq_ready_i is held high and the FIFO is not full.

## Test plan
- Round-robin fairness: channels 0–3 all valid, SRAM always ready, writes -> grants 0,1,2,3,0 on consecutive cycles, one ready bit per cycle.
- Back-pressure lock: ch1 issues a read to addr 5 while ready is low for 3 cycles; ch0 raises valid on cycle 2 -> grant stays ch1, addr stays 5, ch1 fires on cycle 4, ch0 is granted on cycle 5.
- FIFO full (maxOutstanding=4): 4 reads accepted with no returns -> outstanding_o=4. The 5th read holds sram_rq_valid_o=0. A concurrent write on another channel is also blocked, because the lock holds the read. One return -> the 5th read issues the next cycle.
- Return routing: reads accepted from ch2, ch0, ch3; SRAM returns 0xAAAA0002, 0xAAAA0000, 0xAAAA0003 -> ch_rd_valid_o = 0100, 0001, 1000, each one cycle after its rd_valid, with matching data.
- Fixed priority: mode=1, channels 1 and 3 both valid and ready -> ch1 is granted every cycle and ch3 is starved while ch1 stays valid.
- Error and reset: rd_valid with the FIFO empty -> err_unexpected_rd_o=1 and no ch_rd_valid_o. nrst pulsed low mid-lock with 2 reads outstanding -> all state and outputs return to zero. The next return sets the error again.
